float_accum_sequencer: RTL and testbench
========================================

// Module: float_accum_sequencer
// PURPOSE
//  Job-level controller for the Versat floating-point accumulator unit (run/running/delay0/strideMinusOne/in0/out0).
//  Accepts one reduction job at a time: element count, start delay and stride.
//  Issues the run pulse, holds running, streams input elements into in0, drains the adder pipeline and returns the sum.
//  Sits between a data producer (memory/VRead side) and the accumulator FU; the accumulator shares this block's rst.
// PARAMETERS
//  DATA_W   32  float word width (IEEE-754 single)
//  DELAY_W  32  width of the delay0 configuration
//  STRIDE_W 32  width of the strideMinusOne configuration
//  LEN_W    16  width of the element-count field
//  ACC_LAT  6   drain cycles after the last element before out0 holds the final sum
// PORTS
//  clk           in   1         clock, all logic on rising edge
//  rst           in   1         synchronous, active-high reset
//  job_valid_i   in   1         job request
//  job_ready_o   out  1         high only in IDLE
//  job_len_i     in   LEN_W     number of elements to sum (0 legal)
//  job_delay_i   in   DELAY_W   delay0 value for the accumulator
//  job_stride_i  in   STRIDE_W  strideMinusOne value (passed through, not interpreted)
//  in_valid_i    in   1         element valid
//  in_ready_o    out  1         element accepted when in_valid_i & in_ready_o
//  in_data_i     in   DATA_W    element (float)
//  acc_run_o     out  1         to accumulator run
//  acc_running_o out  1         to accumulator running
//  acc_delay_o   out  DELAY_W   to accumulator delay0
//  acc_stride_o  out  STRIDE_W  to accumulator strideMinusOne
//  acc_in_o      out  DATA_W    to accumulator in0
//  acc_out_i     in   DATA_W    from accumulator out0
//  res_valid_o   out  1         result available
//  res_ready_i   in   1         result consumed when res_valid_o & res_ready_i
//  res_data_o    out  DATA_W    final sum
//  busy_o        out  1         state != IDLE
// BEHAVIOUR
//  - Reset: state IDLE; every output 0, except job_ready_o = 1 from the first cycle after reset.
//  - rst mid-job: next cycle is IDLE, the partial sum is discarded and res_valid_o is 0.
//  - States: IDLE -> RUN -> DELAY -> STREAM -> DRAIN -> DONE -> IDLE.
//  - IDLE:
//    - job handshake in cycle T latches len, delay and stride; next state RUN.
//    - acc_delay_o and acc_stride_o drive the latched values from T+1 until the next accept.
//  - RUN (1 cycle):
//    - acc_run_o = 1, acc_running_o = 0.
//    - Next state DELAY if delay != 0; else STREAM if len != 0; else DRAIN.
//  - DELAY:
//    - acc_running_o = 1, in_ready_o = 0, acc_in_o = 0; lasts exactly delay cycles.
//    - Then STREAM, or DRAIN if len == 0.
//  - STREAM:
//    - acc_running_o = 1, in_ready_o = 1.
//    - acc_in_o = in_data_i on a handshake cycle, else 32'h0 (+0.0 bubble, leaves the sum unchanged).
//    - The cycle of the len-th handshake is the last STREAM cycle; then DRAIN.
//  - DRAIN:
//    - acc_running_o = 1, acc_in_o = 0, exactly ACC_LAT cycles.
//    - On the last DRAIN cycle res_data_o <= acc_out_i.
//  - DONE:
//    - acc_running_o = 0, res_valid_o = 1, res_data_o held stable.
//    - On res handshake, next state IDLE; a new job is accepted no earlier than the following cycle.
//  - Latency, back-to-back input, job accepted at T: res_valid_o rises at T + 2 + delay + len + ACC_LAT.
//  - Handshake rules:
//    - in_valid_i outside STREAM is ignored (in_ready_o = 0).
//    - job_valid_i outside IDLE is ignored.
//    - acc_run_o and acc_running_o are never high together.
//  - Counters:
//    - Delay counter is DELAY_W bits; all-ones is legal and counts fully.
//    - Element counter is LEN_W bits, with no wrap within a job.
// TESTING
//  1. Reset: rst 1 cycle -> job_ready_o = 1, all other outputs 0.
//     Assert rst mid-STREAM -> IDLE next cycle, res_valid_o = 0.
//  2. len=4, delay=0, data 3F800000,40000000,40400000,40800000 back-to-back, accept at T ->
//     acc_run_o high at T+1 only; res_valid_o high at T+12; res_data_o = 41200000.
//  3. Same job with in_valid_i low on alternate cycles -> acc_in_o = 0 in bubble cycles; result 41200000.
//  4. delay=3, len=2 (3F800000,BF800000) -> running high 3 cycles with in_ready_o = 0 before the first element; result 0 or 80000000.
//  5. len=0, delay=0 -> in_ready_o never high; res_valid_o at T+8; res_data_o = acc_out_i sampled on the last DRAIN cycle.
//  6. Hold res_ready_i low 5 cycles -> res_valid_o and res_data_o stable, job_ready_o = 0.
//     Release -> IDLE; a second job is accepted the cycle after.

Source files
------------

// File: rtl/float_accum_sequencer.sv
// Job-level controller for the Versat floating-point accumulator: accepts one reduction job,
// sequences run/running, streams elements into in0, drains the adder pipeline and returns the sum.
module float_accum_sequencer #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DELAY_W  = 32,
    parameter int unsigned STRIDE_W = 32,
    parameter int unsigned LEN_W    = 16,
    parameter int unsigned ACC_LAT  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                job_valid_i,
    output logic                job_ready_o,
    input  logic [LEN_W-1:0]    job_len_i,
    input  logic [DELAY_W-1:0]  job_delay_i,
    input  logic [STRIDE_W-1:0] job_stride_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [DATA_W-1:0]   in_data_i,
    output logic                acc_run_o,
    output logic                acc_running_o,
    output logic [DELAY_W-1:0]  acc_delay_o,
    output logic [STRIDE_W-1:0] acc_stride_o,
    output logic [DATA_W-1:0]   acc_in_o,
    input  logic [DATA_W-1:0]   acc_out_i,
    output logic                res_valid_o,
    input  logic                res_ready_i,
    output logic [DATA_W-1:0]   res_data_o,
    output logic                busy_o
);

    localparam int unsigned DrainW = (ACC_LAT > 1) ? $clog2(ACC_LAT) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StDelay,
        StStream,
        StDrain,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [DELAY_W-1:0]  delay_q, delay_d;
    logic [STRIDE_W-1:0] stride_q, stride_d;
    logic [DELAY_W-1:0]  dcnt_q, dcnt_d;
    logic [LEN_W-1:0]    ecnt_q, ecnt_d;
    logic [DrainW-1:0]   drain_q, drain_d;
    logic [DATA_W-1:0]   res_q, res_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            len_q    <= '0;
            delay_q  <= '0;
            stride_q <= '0;
            dcnt_q   <= '0;
            ecnt_q   <= '0;
            drain_q  <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            delay_q  <= delay_d;
            stride_q <= stride_d;
            dcnt_q   <= dcnt_d;
            ecnt_q   <= ecnt_d;
            drain_q  <= drain_d;
            res_q    <= res_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        delay_d       = delay_q;
        stride_d      = stride_q;
        dcnt_d        = dcnt_q;
        ecnt_d        = ecnt_q;
        drain_d       = drain_q;
        res_d         = res_q;
        job_ready_o   = 1'b0;
        in_ready_o    = 1'b0;
        acc_run_o     = 1'b0;
        acc_running_o = 1'b0;
        acc_in_o      = '0;
        res_valid_o   = 1'b0;

        unique case (state_q)
            StIdle: begin
                job_ready_o = 1'b1;
                if (job_valid_i) begin
                    len_d    = job_len_i;
                    delay_d  = job_delay_i;
                    stride_d = job_stride_i;
                    state_d  = StRun;
                end
            end
            StRun: begin
                acc_run_o = 1'b1;
                // Down-counter reaches zero on the last delay cycle, so all-ones counts fully.
                dcnt_d    = delay_q - DELAY_W'(1);
                ecnt_d    = '0;
                drain_d   = '0;
                if (delay_q != '0) begin
                    state_d = StDelay;
                end else if (len_q != '0) begin
                    state_d = StStream;
                end else begin
                    state_d = StDrain;
                end
            end
            StDelay: begin
                acc_running_o = 1'b1;
                if (dcnt_q == '0) begin
                    state_d = (len_q != '0) ? StStream : StDrain;
                end else begin
                    dcnt_d = dcnt_q - DELAY_W'(1);
                end
            end
            StStream: begin
                acc_running_o = 1'b1;
                in_ready_o    = 1'b1;
                // Cycles without a handshake feed +0.0, which leaves the sum unchanged.
                if (in_valid_i) begin
                    acc_in_o = in_data_i;
                    if (ecnt_q == len_q - LEN_W'(1)) begin
                        state_d = StDrain;
                    end else begin
                        ecnt_d = ecnt_q + LEN_W'(1);
                    end
                end
            end
            StDrain: begin
                acc_running_o = 1'b1;
                if (drain_q == DrainW'(ACC_LAT - 1)) begin
                    res_d   = acc_out_i;
                    state_d = StDone;
                end else begin
                    drain_d = drain_q + DrainW'(1);
                end
            end
            StDone: begin
                res_valid_o = 1'b1;
                if (res_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign acc_delay_o  = delay_q;
    assign acc_stride_o = stride_q;
    assign res_data_o   = res_q;
    assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_float_accum_sequencer.sv
// Directed bench for float_accum_sequencer with a behavioural float accumulator on acc_in/acc_out.
module tb_float_accum_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        job_valid;
    logic        job_ready_o;
    logic [15:0] job_len;
    logic [31:0] job_delay;
    logic [31:0] job_stride;
    logic        in_valid;
    logic        in_ready_o;
    logic [31:0] in_data;
    logic        acc_run_o;
    logic        acc_running_o;
    logic [31:0] acc_delay_o;
    logic [31:0] acc_stride_o;
    logic [31:0] acc_in_o;
    logic [31:0] acc_out_i;
    logic        res_valid_o;
    logic        res_ready;
    logic [31:0] res_data_o;
    logic        busy_o;

    int errors = 0;
    int checks = 0;

    logic [31:0] vals [4];
    real         acc_sum;
    logic        acc_ovr = 1'b0;
    logic [31:0] acc_ovr_val = 32'h0;

    always #5 clk = ~clk;

    float_accum_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .job_valid_i  (job_valid),
        .job_ready_o  (job_ready_o),
        .job_len_i    (job_len),
        .job_delay_i  (job_delay),
        .job_stride_i (job_stride),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready_o),
        .in_data_i    (in_data),
        .acc_run_o    (acc_run_o),
        .acc_running_o(acc_running_o),
        .acc_delay_o  (acc_delay_o),
        .acc_stride_o (acc_stride_o),
        .acc_in_o     (acc_in_o),
        .acc_out_i    (acc_out_i),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready),
        .res_data_o   (res_data_o),
        .busy_o       (busy_o)
    );

    function automatic real f2r(input logic [31:0] b);
        real v;
        int  e;
        if (b[30:0] == 31'h0) return 0.0;
        v = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return b[31] ? -v : v;
    endfunction

    function automatic logic [31:0] r2f(input real x);
        real  a;
        int   e;
        logic s;
        if (x == 0.0) return 32'h0;
        s = (x < 0.0);
        a = s ? -x : x;
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0) begin a = a * 2.0; e--; end
        return {s, 8'(e + 127), 23'($rtoi((a - 1.0) * 8388608.0))};
    endfunction

    // Accumulator FU stand-in: cleared by run, sums in0 while running.
    always @(posedge clk) begin
        if (rst || acc_run_o) acc_sum <= 0.0;
        else if (acc_running_o) acc_sum <= acc_sum + f2r(acc_in_o);
    end

    always_comb acc_out_i = acc_ovr ? acc_ovr_val : r2f(acc_sum);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Accept a job, walk it cycle by cycle against the expected phase timeline,
    // hold the result for `hold` cycles, then release it; returns with DUT entering IDLE.
    task automatic run_job(input int len, input logic [31:0] dly, input bit gaps,
                           input logic [31:0] exp_res, input int exp_lat, input int hold);
        int          idx;
        bit          stream;
        logic [31:0] exp_in;
        logic [31:0] stride;
        idx    = 0;
        stride = 32'h0000_0100 + dly;
        @(negedge clk);
        res_ready  = 1'b0;
        job_valid  = 1'b1;
        job_len    = 16'(len);
        job_delay  = dly;
        job_stride = stride;
        in_valid   = 1'b0;
        #1;
        check("job_ready_idle", job_ready_o, 1);
        check("busy_idle", busy_o, 0);
        for (int cyc = 1; cyc <= exp_lat; cyc++) begin
            @(negedge clk);
            job_valid  = 1'b1;
            job_delay  = 32'hDEAD_0000;
            job_stride = 32'hBEEF_0000;
            stream     = (cyc >= 2 + int'(dly)) && (idx < len);
            in_valid   = (idx < len) && (!gaps || (cyc % 2 == 1));
            in_data    = (idx < len) ? vals[idx] : 32'h7F00_1234;
            if (acc_ovr) acc_ovr_val = 32'hA5A5_0000 + cyc;
            exp_in = (stream && in_valid) ? in_data : 32'h0;
            #1;
            check("acc_run", acc_run_o, cyc == 1);
            check("acc_running", acc_running_o, (cyc >= 2) && (cyc < exp_lat));
            check("in_ready", in_ready_o, stream);
            check("acc_in", acc_in_o, exp_in);
            check("res_valid", res_valid_o, cyc == exp_lat);
            check("job_ready_busy", job_ready_o, 0);
            check("acc_delay", acc_delay_o, dly);
            check("acc_stride", acc_stride_o, stride);
            if (stream && in_valid) idx++;
        end
        check("res_data", res_data_o, exp_res);
        in_valid = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            #1;
            check("hold_valid", res_valid_o, 1);
            check("hold_data", res_data_o, exp_res);
            check("hold_job_ready", job_ready_o, 0);
            check("hold_running", acc_running_o, 0);
        end
        @(negedge clk);
        job_valid = 1'b0;
        res_ready = 1'b1;
        #1;
        check("release_valid", res_valid_o, 1);
    endtask

    initial begin
        rst        = 1'b1;
        job_valid  = 1'b0;
        job_len    = '0;
        job_delay  = '0;
        job_stride = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        res_ready  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_job_ready", job_ready_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_run", acc_run_o, 0);
        check("rst_running", acc_running_o, 0);
        check("rst_in_ready", in_ready_o, 0);
        check("rst_res_valid", res_valid_o, 0);
        check("rst_res_data", res_data_o, 0);
        check("rst_acc_in", acc_in_o, 0);
        check("rst_acc_delay", acc_delay_o, 0);
        check("rst_acc_stride", acc_stride_o, 0);

        // 1+2+3+4 = 10.0, back to back; result held 5 cycles before release
        vals[0] = 32'h3F80_0000; vals[1] = 32'h4000_0000;
        vals[2] = 32'h4040_0000; vals[3] = 32'h4080_0000;
        run_job(4, 32'd0, 1'b0, 32'h4120_0000, 12, 5);
        // Same job, input valid on alternate cycles; accepted right after release
        run_job(4, 32'd0, 1'b1, 32'h4120_0000, 16, 0);
        // delay=3, 1.0 + -1.0
        vals[0] = 32'h3F80_0000; vals[1] = 32'hBF80_0000;
        run_job(2, 32'd3, 1'b0, 32'h0000_0000, 13, 0);
        // len=0: result is whatever out0 shows on the last drain cycle (cycle 7)
        acc_ovr = 1'b1;
        run_job(0, 32'd0, 1'b0, 32'hA5A5_0007, 8, 0);
        acc_ovr = 1'b0;

        // Reset in the middle of STREAM
        vals[0] = 32'h3F80_0000; vals[1] = 32'h4000_0000;
        vals[2] = 32'h4040_0000; vals[3] = 32'h4080_0000;
        @(negedge clk);
        res_ready = 1'b0;
        job_valid = 1'b1;
        job_len   = 16'd4;
        job_delay = 32'd0;
        @(negedge clk);
        job_valid = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = vals[0];
        #1;
        check("mid_in_ready", in_ready_o, 1);
        @(negedge clk);
        rst     = 1'b1;
        in_data = vals[1];
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_job_ready", job_ready_o, 1);
        check("mid_rst_res_valid", res_valid_o, 0);
        check("mid_rst_running", acc_running_o, 0);
        check("mid_rst_in_ready", in_ready_o, 0);

        // Clean job after the aborted one
        run_job(4, 32'd0, 1'b0, 32'h4120_0000, 12, 0);
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        check("final_idle", job_ready_o, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
